// File: rtl/cpu_sequencer.sv
// Three-phase multicycle CPU sequencer: FETCH -> EXEC1 -> EXEC2, with bus/ALU
// stall handling, halt detection and saturating retire/cycle counters.
package codes;
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC1  = 2'd1,
        EXEC2  = 2'd2,
        HALTED = 2'd3
    } state_t;
endpackage

module cpu_sequencer #(
    parameter logic [31:0] HALT_ADDR = 32'h0000_0000,
    parameter int          COUNT_W   = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               waitrequest_i,
    input  logic               mem_access_i,
    input  logic               alu_busy_i,
    input  logic [31:0]        pc_next_i,
    output codes::state_t      state_o,
    output logic               advance_o,
    output logic               stall_o,
    output logic               active_o,
    output logic [COUNT_W-1:0] instr_count_o,
    output logic [COUNT_W-1:0] cycle_count_o
);
    import codes::*;

    localparam logic [COUNT_W-1:0] ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    logic [COUNT_W-1:0] r_instr_cnt;
    logic [COUNT_W-1:0] r_cycle_cnt;
    logic               w_active;
    logic               w_exec;
    logic               w_stall;
    logic               w_advance;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    assign w_active  = (r_state != HALTED);
    assign w_exec    = (r_state == EXEC1) || (r_state == EXEC2);
    // Reset gates the qualifiers so nothing commits while the sequencer is held.
    assign w_stall   = ~reset_i & w_active &
                       ((mem_access_i & waitrequest_i) | (w_exec & alu_busy_i));
    assign w_advance = ~reset_i & w_active & ~w_stall;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= FETCH;
            r_instr_cnt <= '0;
            r_cycle_cnt <= '0;
        end else begin
            if (w_active)
                r_cycle_cnt <= sat_inc(r_cycle_cnt);
            if (w_advance) begin
                case (r_state)
                    FETCH:   r_state <= EXEC1;
                    EXEC1:   r_state <= EXEC2;
                    EXEC2: begin
                        r_instr_cnt <= sat_inc(r_instr_cnt);
                        r_state     <= (pc_next_i == HALT_ADDR) ? HALTED : FETCH;
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    assign state_o       = r_state;
    assign advance_o     = w_advance;
    assign stall_o       = w_stall;
    assign active_o      = w_active;
    assign instr_count_o = r_instr_cnt;
    assign cycle_count_o = r_cycle_cnt;
endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: vector table through a scoreboard queue, hand-written
// reset/stall sequences, and a narrow-counter instance for saturation.
module tb_cpu_sequencer;
    import codes::*;

    typedef struct {
        logic   mem;
        logic   wt;
        logic   busy;
        logic [31:0] pc;
        state_t st;
        logic   stall;
        logic   adv;
        logic   act;
        int     ic;
        int     cc;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        waitrequest_i = 1'b0;
    logic        mem_access_i = 1'b0;
    logic        alu_busy_i = 1'b0;
    logic [31:0] pc_next_i = 32'd4;
    state_t      state_o;
    logic        advance_o, stall_o, active_o;
    logic [31:0] instr_count_o, cycle_count_o;

    logic        rst4 = 1'b1;
    logic        wt4 = 1'b0, mem4 = 1'b0, busy4 = 1'b0;
    logic [31:0] pc4 = 32'd4;
    state_t      st4;
    logic        adv4, stall4, act4;
    logic [3:0]  ic4, cc4;

    int tests = 0;
    int fails = 0;
    vec_t tbl[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    cpu_sequencer dut (
        .clk_i(clk), .reset_i(reset_i), .waitrequest_i(waitrequest_i),
        .mem_access_i(mem_access_i), .alu_busy_i(alu_busy_i), .pc_next_i(pc_next_i),
        .state_o(state_o), .advance_o(advance_o), .stall_o(stall_o), .active_o(active_o),
        .instr_count_o(instr_count_o), .cycle_count_o(cycle_count_o)
    );

    cpu_sequencer #(.HALT_ADDR(32'h0), .COUNT_W(4)) dut4 (
        .clk_i(clk), .reset_i(rst4), .waitrequest_i(wt4),
        .mem_access_i(mem4), .alu_busy_i(busy4), .pc_next_i(pc4),
        .state_o(st4), .advance_o(adv4), .stall_o(stall4), .active_o(act4),
        .instr_count_o(ic4), .cycle_count_o(cc4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic add(input logic mem, input logic wt, input logic busy, input logic [31:0] pc,
                       input state_t st, input logic stall, input logic adv, input logic act,
                       input int ic, input int cc);
        vec_t v;
        v.mem = mem; v.wt = wt; v.busy = busy; v.pc = pc; v.st = st;
        v.stall = stall; v.adv = adv; v.act = act; v.ic = ic; v.cc = cc;
        tbl.push_back(v);
    endtask

    task automatic chk_all(input string pfx, input state_t st, input logic stall, input logic adv,
                           input logic act, input int ic, input int cc);
        chk({pfx, " state"}, state_o, st);
        chk({pfx, " stall"}, stall_o, stall);
        chk({pfx, " advance"}, advance_o, adv);
        chk({pfx, " active"}, active_o, act);
        chk({pfx, " instr"}, instr_count_o, ic);
        chk({pfx, " cycles"}, cycle_count_o, cc);
    endtask

    initial begin
        vec_t e;
        //  mem wt busy pc  state   stl adv act ic cc
        add(0, 0, 0, 4, FETCH,  0, 1, 1, 0, 0);   // two clean instructions
        add(0, 0, 0, 4, EXEC1,  0, 1, 1, 0, 1);
        add(0, 0, 0, 4, EXEC2,  0, 1, 1, 0, 2);
        add(0, 0, 0, 4, FETCH,  0, 1, 1, 1, 3);
        add(0, 0, 0, 4, EXEC1,  0, 1, 1, 1, 4);
        add(0, 0, 0, 4, EXEC2,  0, 1, 1, 1, 5);
        add(1, 1, 0, 4, FETCH,  1, 0, 1, 2, 6);   // 3-cycle bus stall in FETCH
        add(1, 1, 0, 4, FETCH,  1, 0, 1, 2, 7);
        add(1, 1, 0, 4, FETCH,  1, 0, 1, 2, 8);
        add(1, 0, 1, 4, FETCH,  0, 1, 1, 2, 9);   // busy ignored in FETCH
        add(0, 0, 0, 4, EXEC1,  0, 1, 1, 2, 10);
        add(0, 0, 1, 4, EXEC2,  1, 0, 1, 2, 11);  // 5-cycle ALU stall in EXEC2
        add(0, 0, 1, 4, EXEC2,  1, 0, 1, 2, 12);
        add(0, 0, 1, 4, EXEC2,  1, 0, 1, 2, 13);
        add(0, 0, 1, 4, EXEC2,  1, 0, 1, 2, 14);
        add(0, 0, 1, 4, EXEC2,  1, 0, 1, 2, 15);
        add(0, 0, 0, 4, EXEC2,  0, 1, 1, 2, 16);
        add(0, 0, 0, 4, FETCH,  0, 1, 1, 3, 17);
        add(1, 1, 1, 4, EXEC1,  1, 0, 1, 3, 18);  // bus + ALU together, then bus alone
        add(1, 1, 0, 4, EXEC1,  1, 0, 1, 3, 19);
        add(0, 0, 0, 4, EXEC1,  0, 1, 1, 3, 20);
        add(0, 0, 0, 0, EXEC2,  0, 1, 1, 3, 21);  // halting instruction
        add(0, 0, 0, 4, HALTED, 0, 0, 0, 4, 22);
        add(1, 1, 1, 4, HALTED, 0, 0, 0, 4, 22);
        add(0, 1, 0, 0, HALTED, 0, 0, 0, 4, 22);

        // Reset state, with a would-be stall on the inputs
        mem_access_i = 1'b1; waitrequest_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", FETCH, 0, 0, 1, 0, 0);
        reset_i = 1'b0;

        foreach (tbl[i]) begin
            mem_access_i = tbl[i].mem; waitrequest_i = tbl[i].wt;
            alu_busy_i = tbl[i].busy; pc_next_i = tbl[i].pc;
            exp_q.push_back(tbl[i]);
            #2;
            e = exp_q.pop_front();
            chk_all($sformatf("row%0d", i), e.st, e.stall, e.adv, e.act, e.ic, e.cc);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset out of HALTED, between clock edges
        mem_access_i = 1'b0; waitrequest_i = 1'b0; alu_busy_i = 1'b0; pc_next_i = 32'd4;
        #2 reset_i = 1'b1;
        #1 chk_all("halt_rst", FETCH, 0, 0, 1, 0, 0);
        reset_i = 1'b0;
        #1 chk("restart advance", advance_o, 1'b1);
        @(posedge clk); #1;
        chk("restart state", state_o, EXEC1);
        alu_busy_i = 1'b1;
        #1 chk("e1 busy stall", stall_o, 1'b1);
        @(posedge clk); #1;
        chk("e1 held", state_o, EXEC1);
        chk("e1 held cycles", cycle_count_o, 32'd2);
        // Reset pulse in the middle of the EXEC1 stall
        #1 reset_i = 1'b1;
        #1 chk_all("stall_rst", FETCH, 0, 0, 1, 0, 0);
        reset_i = 1'b0;
        #1 chk("post-rst busy ignored", stall_o, 1'b0);
        @(posedge clk); #1;
        chk("post-rst state", state_o, EXEC1);
        chk("post-rst cycles", cycle_count_o, 32'd1);
        alu_busy_i = 1'b0;
        @(posedge clk); #1;
        chk("post-rst e2", state_o, EXEC2);
        @(posedge clk); #1;
        chk("post-rst fetch", state_o, FETCH);
        chk("post-rst instr", instr_count_o, 32'd1);

        // Narrow counter saturation
        rst4 = 1'b0;
        #1 chk("w4 start", {28'd0, cc4}, 32'd0);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            chk($sformatf("w4 cyc%0d", k), {28'd0, cc4}, (k > 15) ? 32'd15 : k);
        end
        chk("w4 state", st4, EXEC2);
        chk("w4 instr", {28'd0, ic4}, 32'd6);
        chk("w4 active", act4, 1'b1);
        chk("w4 advance", adv4, 1'b1);
        chk("w4 stall", stall4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL provide parameter HALT_ADDR, default 32'h0000_0000, the next-PC value that terminates execution.
REQ-002 SHALL provide parameter COUNT_W, default 32, the width of the performance counters.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_i, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port waitrequest_i, input, 1, memory-bus stall from the Avalon-style RAM.
REQ-006 SHALL have port mem_access_i, input, 1, high when the current state issues a RAM read or write.
REQ-007 SHALL have port alu_busy_i, input, 1, high while the multi-cycle mult/div unit is computing.
REQ-008 SHALL have port pc_next_i, input, 32, the PC value to be committed at the end of EXEC2.
REQ-009 SHALL have port state_o, output, codes::state_t; the encoding contains FETCH, EXEC1, EXEC2 and HALTED.
REQ-010 SHALL have port advance_o, output, 1, high in a cycle where state_o moves on (commit qualifier for pc/ir/reg/ram write enables).
REQ-011 SHALL have port stall_o, output, 1, high in a cycle where state_o holds because of a stall.
REQ-012 SHALL have port active_o, output, 1, high while the CPU is executing.
REQ-013 SHALL have port instr_count_o, output, COUNT_W, the number of retired instructions.
REQ-014 SHALL have port cycle_count_o, output, COUNT_W, the number of active cycles.

Function
REQ-015 SHALL compute stall = active_o & ((mem_access_i & waitrequest_i) | ((state_o==EXEC1 | state_o==EXEC2) & alu_busy_i)), combinationally.
REQ-016 SHALL drive stall_o = stall and advance_o = active_o & ~stall, both combinationally.
REQ-017 SHALL ignore alu_busy_i in FETCH.
REQ-018 SHALL ignore all inputs in HALTED.
REQ-019 SHALL transition FETCH->EXEC1 and EXEC1->EXEC2 on a clock edge where advance_o=1, and hold state otherwise.
REQ-020 SHALL, in EXEC2 with advance_o=1, go to HALTED if pc_next_i==HALT_ADDR, else go to FETCH.
REQ-021 SHALL keep HALTED absorbing until reset_i is asserted.
REQ-022 SHALL drive active_o low in HALTED and high in every other state.
REQ-023 SHALL drive active_o low combinationally in the same cycle state_o reads HALTED.
REQ-024 SHALL increment instr_count_o by 1 on each EXEC2 edge with advance_o=1, including the halting instruction.
REQ-025 SHALL increment cycle_count_o by 1 on every edge where active_o=1, including stalled cycles.
REQ-026 SHALL saturate both counters at all-ones; they SHALL never wrap to zero.
REQ-027 SHALL let a stall of any length (mem and busy together, or back-to-back) only hold the state, with no skipped or repeated state.
REQ-028 SHALL make state latency, absent stalls, exactly 3 cycles per instruction: FETCH, EXEC1, EXEC2.

Reset
REQ-029 SHALL, while reset_i=1, immediately and independently of clk_i force state_o=FETCH, active_o=1 and both counters to 0.
REQ-030 SHALL force advance_o=0 and stall_o=0 while reset_i=1.
REQ-031 SHALL abandon any stall in progress when reset is asserted.
REQ-032 SHALL make the first rising edge after reset_i falls evaluate FETCH normally.
REQ-033 SHALL apply reset from HALTED identically, restarting execution.

Verification
REQ-034 SHALL cover: reset, then 2 instructions, no stalls, pc_next_i=4 -> states F,E1,E2,F,E1,E2; instr_count_o=2; cycle_count_o=6.
REQ-035 SHALL cover: mem_access_i=1 and waitrequest_i=1 for 3 cycles in FETCH -> state_o holds FETCH 4 cycles; stall_o=1 for 3; cycle_count_o counts all 4.
REQ-036 SHALL cover: alu_busy_i=1 for 5 cycles in EXEC2 -> EXEC2 held 6 cycles; instr_count_o increments once; alu_busy_i=1 in FETCH -> no stall.
REQ-037 SHALL cover: EXEC2 with pc_next_i=0 -> HALTED next edge; active_o=0; instr_count_o incremented; later waitrequest_i/alu_busy_i toggles -> no change.
REQ-038 SHALL cover: reset_i pulsed asynchronously mid-EXEC1 stall -> state_o=FETCH, counters 0, before the next clock edge; then normal sequencing.
REQ-039 SHALL cover: COUNT_W=4, 20 active cycles -> cycle_count_o reaches 4'hF and stays there.
